seq_hit_monitor: RTL and testbench

Windowed detection-rate monitor that sits directly downstream of the Moore sequence detectors (non-overlapping and overlapping). It consumes the detector's registered output `z`, converts each detection into a single-cycle event, and counts events over fixed-length windows of enabled cycles. It raises a sticky alarm when any completed window reaches a programmable hit threshold, and it also keeps a saturating lifetime hit count.

---
 rtl/seq_hit_monitor.sv | 96 +++++++++
 tb/tb_seq_hit_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_monitor.sv
// Windowed detection-rate monitor for a Moore sequence detector: turns each rising edge of z_in
// into one hit, counts hits per fixed window of enabled cycles and over the lifetime, flags hot windows.
module seq_hit_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             z_in,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic             win_done,
  output logic             alarm
);

  localparam int                WPOS_W    = $clog2(WINDOW);
  localparam logic [WPOS_W-1:0] WPOS_LAST = WPOS_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  THRESH_V  = CNT_W'(THRESH);

  logic              z_prev;
  logic [WPOS_W-1:0] wpos;
  logic [CNT_W-1:0]  whits;

  logic              hit;
  logic              win_end;
  logic [CNT_W-1:0]  total_inc;
  logic [CNT_W-1:0]  whits_next;

  // z_prev follows z_in even while disabled, so a level that rose during en=0 is never counted later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_prev <= 1'b0;
    end else begin
      z_prev <= z_in;
    end
  end

  always_comb begin
    hit        = z_in & ~z_prev & en & ~clr;
    win_end    = en & ~clr & (wpos == WPOS_LAST);
    total_inc  = (total_cnt == CNT_MAX) ? total_cnt : total_cnt + CNT_W'(1);
    whits_next = (hit && (whits != CNT_MAX)) ? whits + CNT_W'(1) : whits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_pulse <= 1'b0;
      total_cnt <= '0;
    end else if (clr) begin
      hit_pulse <= 1'b0;
      total_cnt <= '0;
    end else begin
      hit_pulse <= hit;
      if (hit) begin
        total_cnt <= total_inc;
      end
    end
  end

  // whits_next already folds in a hit on the closing cycle, so that hit belongs to the closing window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wpos     <= '0;
      whits    <= '0;
      win_cnt  <= '0;
      win_done <= 1'b0;
      alarm    <= 1'b0;
    end else if (clr) begin
      wpos     <= '0;
      whits    <= '0;
      win_cnt  <= '0;
      win_done <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      win_done <= win_end;
      if (en) begin
        wpos <= win_end ? '0 : wpos + WPOS_W'(1);
      end
      if (win_end) begin
        win_cnt <= whits_next;
        whits   <= '0;
        if (whits_next >= THRESH_V) begin
          alarm <= 1'b1;
        end
      end else begin
        whits <= whits_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor: directed scenarios plus randomized traffic against a
// behavioural model, run on a default instance and a narrow (CNT_W=2, THRESH=2) instance in parallel.
module tb_seq_hit_monitor;

  localparam int WINDOW = 16;

  logic clk = 1'b0;
  logic rst, en, clr, z_in;

  logic       hit_pulse_a, win_done_a, alarm_a;
  logic [7:0] total_cnt_a, win_cnt_a;
  logic       hit_pulse_b, win_done_b, alarm_b;
  logic [1:0] total_cnt_b, win_cnt_b;

  int tests = 0;
  int fails = 0;

  // Reference model: counts enabled edges since the last clear and closes a window every WINDOW of them.
  int m_total[2];
  int m_whits[2];
  int m_wcnt[2];
  bit m_alarm[2];
  int m_edges;
  bit m_hp, m_wd, m_zprev;
  int maxv[2] = '{255, 3};
  int thr[2]  = '{3, 2};

  seq_hit_monitor #(.WINDOW(WINDOW), .CNT_W(8), .THRESH(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .z_in(z_in),
    .hit_pulse(hit_pulse_a), .total_cnt(total_cnt_a), .win_cnt(win_cnt_a),
    .win_done(win_done_a), .alarm(alarm_a)
  );

  seq_hit_monitor #(.WINDOW(WINDOW), .CNT_W(2), .THRESH(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .z_in(z_in),
    .hit_pulse(hit_pulse_b), .total_cnt(total_cnt_b), .win_cnt(win_cnt_b),
    .win_done(win_done_b), .alarm(alarm_b)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_total[i] = 0;
      m_whits[i] = 0;
      m_wcnt[i]  = 0;
      m_alarm[i] = 1'b0;
    end
    m_edges = 0;
    m_hp    = 1'b0;
    m_wd    = 1'b0;
  endtask

  task automatic model_edge();
    bit h;
    h = z_in && !m_zprev && en && !clr;
    m_zprev = z_in;
    if (clr) begin
      model_clear();
    end else begin
      m_hp = h;
      m_wd = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_total[i] = sat(m_total[i] + int'(h), maxv[i]);
        m_whits[i] = sat(m_whits[i] + int'(h), maxv[i]);
      end
      if (en) begin
        m_edges++;
        if (m_edges % WINDOW == 0) begin
          m_wd = 1'b1;
          for (int i = 0; i < 2; i++) begin
            m_wcnt[i]  = m_whits[i];
            m_whits[i] = 0;
            if (m_wcnt[i] >= thr[i]) m_alarm[i] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_a();
    return {m_hp, 8'(m_total[0]), 8'(m_wcnt[0]), m_wd, m_alarm[0]};
  endfunction

  function automatic logic [6:0] exp_b();
    return {m_hp, 2'(m_total[1]), 2'(m_wcnt[1]), m_wd, m_alarm[1]};
  endfunction

  task automatic step(input bit e, input bit c, input bit z);
    en   = e;
    clr  = c;
    z_in = z;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    clr  = 1'b0;
    z_in = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_clear();
    m_zprev = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    clr  = 1'b0;
    z_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL reset_a: got %h expected 0",
               {hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a});
    end
    tests++;
    if ({hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b} !== 7'd0) begin
      fails++;
      $display("[TB] FAIL reset_b: got %h expected 0",
               {hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b});
    end
    #2;
    rst = 1'b0;
    model_clear();
    m_zprev = 1'b0;
  endtask

  task automatic test_single_hits();
    logic exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      exp = (k == 2 || k == 5 || k == 9);
      step(1'b1, 1'b0, exp);
      tests++;
      if (hit_pulse_a !== exp) begin
        fails++;
        $display("[TB] FAIL single_hit_pulse edge %0d: got %b expected %b", k, hit_pulse_a, exp);
      end
    end
    tests++;
    if ({total_cnt_a, win_cnt_a, win_done_a, alarm_a} !== {8'd3, 8'd3, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL single_hits_window: total=%0d win=%0d done=%b alarm=%b expected 3 3 1 1",
               total_cnt_a, win_cnt_a, win_done_a, alarm_a);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if (hit_pulse_a !== (k == 1)) begin
        fails++;
        $display("[TB] FAIL level_hold_pulse edge %0d: got %b expected %b", k, hit_pulse_a, k == 1);
      end
    end
    tests++;
    if (total_cnt_a !== 8'd1) begin
      fails++;
      $display("[TB] FAIL level_hold_total: got %0d expected 1", total_cnt_a);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    tests++;
    if ({hit_pulse_a, total_cnt_a} !== {1'b1, 8'd2}) begin
      fails++;
      $display("[TB] FAIL level_rehit: pulse=%b total=%0d expected 1 2", hit_pulse_a, total_cnt_a);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, k == 16);
    tests++;
    if ({hit_pulse_a, win_done_a, win_cnt_a} !== {1'b1, 1'b1, 8'd1}) begin
      fails++;
      $display("[TB] FAIL boundary_last_edge: pulse=%b done=%b win=%0d expected 1 1 1",
               hit_pulse_a, win_done_a, win_cnt_a);
    end
    do_reset();
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, k == 17);
    tests++;
    if ({win_done_a, win_cnt_a} !== {1'b1, 8'd0}) begin
      fails++;
      $display("[TB] FAIL boundary_first_window: done=%b win=%0d expected 1 0", win_done_a, win_cnt_a);
    end
    step(1'b1, 1'b0, 1'b1);
    for (int k = 18; k <= 32; k++) step(1'b1, 1'b0, 1'b0);
    tests++;
    if ({win_done_a, win_cnt_a, total_cnt_a} !== {1'b1, 8'd1, 8'd1}) begin
      fails++;
      $display("[TB] FAIL boundary_second_window: done=%b win=%0d total=%0d expected 1 1 1",
               win_done_a, win_cnt_a, total_cnt_a);
    end
  endtask

  task automatic test_enable_gating();
    logic e;
    do_reset();
    for (int k = 1; k <= 23; k++) begin
      e = !(k >= 4 && k <= 10);
      step(e, 1'b0, k >= 6 && k <= 12);
      tests++;
      if ({hit_pulse_a, win_done_a, total_cnt_a} !== {1'b0, (k == 23), 8'd0}) begin
        fails++;
        $display("[TB] FAIL enable_gating edge %0d: pulse=%b done=%b total=%0d expected 0 %b 0",
                 k, hit_pulse_a, win_done_a, total_cnt_a, k == 23);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, (k % 2 == 1) && k <= 9);
    tests++;
    if ({total_cnt_b, win_cnt_b, win_done_b, alarm_b} !== {2'd3, 2'd3, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL saturation_b: total=%0d win=%0d done=%b alarm=%b expected 3 3 1 1",
               total_cnt_b, win_cnt_b, win_done_b, alarm_b);
    end
    tests++;
    if ({total_cnt_a, win_cnt_a, alarm_a} !== {8'd5, 8'd5, 1'b1}) begin
      fails++;
      $display("[TB] FAIL saturation_a: total=%0d win=%0d alarm=%b expected 5 5 1",
               total_cnt_a, win_cnt_a, alarm_a);
    end
    for (int k = 17; k <= 32; k++) step(1'b1, 1'b0, 1'b0);
    tests++;
    if ({total_cnt_b, win_cnt_b, win_done_b, alarm_b} !== {2'd3, 2'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL sticky_alarm_b: total=%0d win=%0d done=%b alarm=%b expected 3 0 1 1",
               total_cnt_b, win_cnt_b, win_done_b, alarm_b);
    end
    tests++;
    if ({win_cnt_a, alarm_a} !== {8'd0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL sticky_alarm_a: win=%0d alarm=%b expected 0 1", win_cnt_a, alarm_a);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    for (int k = 1; k <= 15; k++) step(1'b1, 1'b0, k == 2 || k == 4 || k == 6);
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if ({hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL clear_priority_a: got %h expected 0",
               {hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a});
    end
    tests++;
    if ({hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b} !== 7'd0) begin
      fails++;
      $display("[TB] FAIL clear_priority_b: got %h expected 0",
               {hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b});
    end
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if (win_done_a !== (k == 16)) begin
        fails++;
        $display("[TB] FAIL clear_window_restart edge %0d: got %b expected %b", k, win_done_a, k == 16);
      end
    end
  endtask

  task automatic test_reset_mid_window();
    do_reset();
    for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, k == 2 || k == 4 || k == 6);
    rst = 1'b1;
    #1;
    tests++;
    if ({hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a} !== 19'd0) begin
      fails++;
      $display("[TB] FAIL async_reset_a: got %h expected 0",
               {hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a});
    end
    #2;
    rst = 1'b0;
    model_clear();
    m_zprev = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if ({win_done_a, win_cnt_a} !== {(k == 16), 8'd0}) begin
        fails++;
        $display("[TB] FAIL reset_window_restart edge %0d: done=%b win=%0d expected %b 0",
                 k, win_done_a, win_cnt_a, k == 16);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4);
      tests++;
      if ({hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a} !== exp_a()) begin
        fails++;
        $display("[TB] FAIL random_a cycle %0d: got %h expected %h", n,
                 {hit_pulse_a, total_cnt_a, win_cnt_a, win_done_a, alarm_a}, exp_a());
      end
      tests++;
      if ({hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b} !== exp_b()) begin
        fails++;
        $display("[TB] FAIL random_b cycle %0d: got %h expected %h", n,
                 {hit_pulse_b, total_cnt_b, win_cnt_b, win_done_b, alarm_b}, exp_b());
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    clr  = 1'b0;
    z_in = 1'b0;
    test_reset();
    test_single_hits();
    test_level_hold();
    test_boundary();
    test_enable_gating();
    test_saturation();
    test_clear_priority();
    test_reset_mid_window();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
